md4_round1_inverse: RTL and testbench
=====================================

# md4_round1_inverse

Iterative inverse of the 16-step MD4 round-1 compression stage. Given a post-round-1 state (a, b, c, d) and the 512-bit message block that produced it, it recovers the pre-round-1 state by undoing one step per clock, from step 15 down to step 0. It sits beside the round-1 stage as its decoder and is used for self-check and verification of that stage. It uses a valid/ready handshake on both the input and the output side.

## Interface
- No parameters; word width is fixed at 32 and step count at 16.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  in_a..in_d and in_x are valid this cycle.
- in_ready  output  1  block idle, can accept a job.
- in_a, in_b, in_c, in_d  input  32 each  post-round-1 state words.
- in_x  input  512  message block; word i = in_x[32*i+31 : 32*i], i = 0..15.
- out_valid  output  1  out_a..out_d hold the recovered state.
- out_ready  input  1  consumer accepts the result.
- out_a, out_b, out_c, out_d  output  32 each  recovered pre-round-1 state.

## Operation
- Forward step i (definition only): target = rotl32(target + F(p,q,r) + X[i], S[i]). There is no additive constant in round 1.
- F(p,q,r) = (p & q) | (~p & r). F is bitwise.
- S[i] = 3, 7, 11, 19 for i mod 4 = 0, 1, 2, 3.
- Target register and F arguments by i mod 4:
  - 0: target A, F(B,C,D).
  - 1: target D, F(A,B,C).
  - 2: target C, F(D,A,B).
  - 3: target B, F(C,D,A).
- Inverse step i: target = rotr32(target, S[i]) − F(p,q,r) − X[i], modulo 2^32. The other three registers are unchanged and are used in their current values.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load A..D and X from the inputs, set step=15, and go to RUN.
  - RUN: in_ready=0. Each cycle apply inverse step[step]. If step==0, go to DONE; else decrement step.
  - DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE.
- Exactly one combinational step unit per cycle. The S, target and F operand selection is a mux on step[1:0].
- in_valid outside IDLE is ignored. in_x is not sampled after the accept edge.
- out_a..out_d are driven from the state registers. Their value is defined only while out_valid=1; bench checks only then.

## Timing
- Reset (rst_n=0 at an edge): state←IDLE, step←0, A..D←0, X←0, in_ready=1, out_valid=0.
- Reset overrides any state, including mid-RUN. The in-flight job is discarded and no out_valid is produced for it.
- Latency: the accept edge is E0. The 16 steps are applied at edges E1..E16. out_valid is high from E16 until the output handshake edge.
- Output handshake: out_valid&&out_ready at edge En. out_valid=0 and in_ready=1 after En.
- Earliest next accept is at edge En+1. Throughput is one job per 18 cycles at best.
- Backpressure: out_ready low holds DONE indefinitely with outputs stable.
- Simultaneous in_valid with the output handshake in DONE is not accepted; in_ready is 0 in that cycle.
- Counter step is 4 bits. The decrement 0→15 never occurs, because step==0 exits RUN.

## Structure
- Shared package md4_pkg holds:
  - WORD_W=32.
  - the rotate-amount constants R1_S0..R1_S3 = 3, 7, 11, 19.
  - the F function.
  - state enum {IDLE, RUN, DONE}.
  - rotl32 and rotr32 functions.
- Forward and inverse round-1 blocks both use this package.
- One sub-module: md4_r1_inv_step. It is combinational: inputs (a,b,c,d, x_word, step[1:0]), outputs the next (a,b,c,d).
- The FSM, counter and registers live in the top.

## Test plan
- Zero vector: in_a..in_d=0, in_x=0 → out_valid at E16; out_a..out_d=0.
- Round trip: forward model on IV 67452301/efcdab89/98badcfe/10325476 with in_x = 512'h41686D61642055726162698000…0059 gives state S. Feed S plus the same in_x → outputs equal the IV exactly.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs stable and in_ready=0 throughout. Raise out_ready → in_ready=1 on the next cycle.
- Busy ignore: pulse in_valid with different data at E5 → result still matches the first job.
- Reset mid-op: rst_n=0 at E8 → next cycle in_ready=1, out_valid=0. A new job with the zero vector completes correctly in 16 cycles.
- Randomized: 200 random (state, x) pairs run through the forward model → inverse returns the original state, with random out_ready stalls.

Source files
------------

// File: rtl/md4_pkg.sv
// Shared MD4 round-1 definitions: word width, rotate amounts, F function,
// FSM state encoding and rotate helpers.
package md4_pkg;

    localparam int unsigned WORD_W = 32;

    localparam int unsigned R1_S0 = 3;
    localparam int unsigned R1_S1 = 7;
    localparam int unsigned R1_S2 = 11;
    localparam int unsigned R1_S3 = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] md4_f(input logic [WORD_W-1:0] p,
                                                input logic [WORD_W-1:0] q,
                                                input logic [WORD_W-1:0] r);
        return (p & q) | (~p & r);
    endfunction

    // Doubled-word shifts keep rotate-by-zero well defined.
    function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] v,
                                                 input int unsigned s);
        logic [2*WORD_W-1:0] t;
        t = {v, v} << s;
        return t[2*WORD_W-1:WORD_W];
    endfunction

    function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] v,
                                                 input int unsigned s);
        logic [2*WORD_W-1:0] t;
        t = {v, v} >> s;
        return t[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/md4_r1_inv_step.sv
// One inverse MD4 round-1 step; step[1:0] selects target, F operands and rotate.
module md4_r1_inv_step
    import md4_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [WORD_W-1:0] c,
    input  logic [WORD_W-1:0] d,
    input  logic [WORD_W-1:0] x_word,
    input  logic [1:0]        step,
    output logic [WORD_W-1:0] a_next,
    output logic [WORD_W-1:0] b_next,
    output logic [WORD_W-1:0] c_next,
    output logic [WORD_W-1:0] d_next
);

    always_comb begin
        a_next = a;
        b_next = b;
        c_next = c;
        d_next = d;
        unique case (step)
            2'd0: a_next = rotr32(a, R1_S0) - md4_f(b, c, d) - x_word;
            2'd1: d_next = rotr32(d, R1_S1) - md4_f(a, b, c) - x_word;
            2'd2: c_next = rotr32(c, R1_S2) - md4_f(d, a, b) - x_word;
            2'd3: b_next = rotr32(b, R1_S3) - md4_f(c, d, a) - x_word;
            default: ;
        endcase
    end

endmodule

// File: rtl/md4_round1_inverse.sv
// Iterative MD4 round-1 inverse: undoes steps 15..0, one per clock, with
// valid/ready handshakes on both sides.
module md4_round1_inverse
    import md4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_c,
    input  logic [31:0] in_d,
    input  logic [511:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_c,
    output logic [31:0] out_d
);

    state_t              state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic [WORD_W-1:0]   a_q, b_q, c_q, d_q;
    logic [WORD_W-1:0]   a_d, b_d, c_d, d_d;
    logic [16*WORD_W-1:0] x_q, x_d;
    logic [WORD_W-1:0]   a_nxt, b_nxt, c_nxt, d_nxt;
    logic [WORD_W-1:0]   x_word;

    assign x_word = x_q[WORD_W*step_q +: WORD_W];

    md4_r1_inv_step u_step (
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .d      (d_q),
        .x_word (x_word),
        .step   (step_q[1:0]),
        .a_next (a_nxt),
        .b_next (b_nxt),
        .c_next (c_nxt),
        .d_next (d_nxt)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        x_d     = x_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    c_d     = in_c;
                    d_d     = in_d;
                    x_d     = in_x;
                    step_d  = 4'd15;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d = a_nxt;
                b_d = b_nxt;
                c_d = c_nxt;
                d_d = d_nxt;
                if (step_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    step_d = step_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            x_q     <= x_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_c     = c_q;
    assign out_d     = d_q;

endmodule

// File: tb/tb_md4_round1_inverse.sv
// Self-checking bench for md4_round1_inverse: forward model feeds a scoreboard.
module tb_md4_round1_inverse;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a, in_b, in_c, in_d;
    logic [511:0] in_x;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_a, out_b, out_c, out_d;

    int total = 0;
    int bad   = 0;
    logic [127:0] exp_q[$];

    md4_round1_inverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] p, q, r);
        return (p & q) | (~p & r);
    endfunction

    function automatic logic [127:0] fwd(input logic [31:0] a, b, c, d,
                                         input logic [511:0] x);
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = x[32*i +: 32];
            case (i % 4)
                0: a = rl(a + ff(b, c, d) + w, 3);
                1: d = rl(d + ff(a, b, c) + w, 7);
                2: c = rl(c + ff(d, a, b) + w, 11);
                default: b = rl(b + ff(c, d, a) + w, 19);
            endcase
        end
        return {a, b, c, d};
    endfunction

    // Feeds a post-round-1 state; the original pre-round-1 state is expected back.
    // Returns at accept edge + 1.
    task automatic send(input logic [127:0] orig, input logic [511:0] x);
        logic [127:0] s;
        int n;
        s = fwd(orig[127:96], orig[95:64], orig[63:32], orig[31:0], x);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_wait: in_ready=%b required 1", in_ready);
        end
        {in_a, in_b, in_c, in_d} = s;
        in_x     = x;
        in_valid = 1'b1;
        exp_q.push_back(orig);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x     = '0;
    endtask

    task automatic wait_out(output bit ok);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (out_valid === 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_x = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        logic [127:0] e;
        send(128'h0, 512'h0);
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_early: out_valid=%b at E15 required 0", out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL zero_latency: out_valid=%b at E16 required 1", out_valid);
        end
        e = exp_q.pop_front();
        total++;
        if ({out_a, out_b, out_c, out_d} !== e) begin
            bad++;
            $display("FAIL zero_data: got %h required %h", {out_a, out_b, out_c, out_d}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL zero_handshake: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_round_trip;
        logic [511:0] x;
        logic [127:0] e;
        bit ok;
        x = '0;
        x[511:408] = 104'h41686D61642055726162698000;
        x[15:0]    = 16'h0059;
        send(128'h67452301_efcdab89_98badcfe_10325476, x);
        wait_out(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {out_a, out_b, out_c, out_d} !== 128'h67452301_efcdab89_98badcfe_10325476) begin
            bad++;
            $display("FAIL round_trip: valid=%b got %h required %h", ok,
                     {out_a, out_b, out_c, out_d}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [127:0] e;
        logic [127:0] held;
        bit ok;
        send(128'h01234567_89abcdef_fedcba98_76543210,
             {16{32'hdeadbeef}} ^ {512{1'b1}});
        wait_out(ok);
        e = exp_q.pop_front();
        held = {out_a, out_b, out_c, out_d};
        total++;
        if (!ok || held !== e) begin
            bad++;
            $display("FAIL bp_data: valid=%b got %h required %h", ok, held, e);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_a, out_b, out_c, out_d} !== e) begin
                bad++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b got %h required 1/0 %h",
                         i, out_valid, in_ready, {out_a, out_b, out_c, out_d}, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_busy_ignore;
        logic [127:0] e;
        bit ok;
        send(128'h11111111_22222222_33333333_44444444, {16{32'h5a5aa5a5}});
        repeat (4) @(posedge clk);
        #1;
        in_a = 32'hffffffff; in_b = 32'h0; in_c = 32'h12345678; in_d = 32'h9abcdef0;
        in_x = {512{1'b1}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = '0;
        wait_out(ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || {out_a, out_b, out_c, out_d} !== e) begin
            bad++;
            $display("FAIL busy_ignore: valid=%b got %h required %h", ok,
                     {out_a, out_b, out_c, out_d}, e);
        end
        // Simultaneous in_valid with the output handshake must not start a job.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL done_no_accept: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] e;
        logic [127:0] dropped;
        send(128'hcafebabe_0badf00d_13579bdf_2468ace0, {16{32'h0f1e2d3c}});
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dropped = exp_q.pop_back();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b required 1/0 (job %h)",
                     in_ready, out_valid, dropped);
        end
        send(128'h0, 512'h0);
        repeat (15) @(posedge clk);
        #1;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || {out_a, out_b, out_c, out_d} !== e) begin
            bad++;
            $display("FAIL reset_mid_rerun: valid=%b got %h required 1 %h", out_valid,
                     {out_a, out_b, out_c, out_d}, e);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [127:0] orig, e;
        logic [511:0] x;
        bit ok;
        for (int j = 0; j < 200; j++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 16; k++) x[32*k +: 32] = $urandom;
            send(orig, x);
            wait_out(ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            e = exp_q.pop_front();
            total++;
            if (!ok || out_valid !== 1'b1 || {out_a, out_b, out_c, out_d} !== e) begin
                bad++;
                $display("FAIL random[%0d]: valid=%b got %h required %h", j, out_valid,
                         {out_a, out_b, out_c, out_d}, e);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_round_trip();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
